// File: rtl/bus_arbiter_ctrl_if.sv
// Handshake and datapath-select bundle between the two bus masters and the arbiter.
// The master modport is the requesting side; the slave modport is the arbiter itself.
interface bus_arbiter_ctrl_if #(
  parameter int SLAVE_LEN  = 2,
  parameter int NUM_SLAVES = 3
);
  logic                  m1_request;
  logic                  m2_request;
  logic [SLAVE_LEN-1:0]  m1_slave_sel;
  logic [SLAVE_LEN-1:0]  m2_slave_sel;
  logic                  trans_done;
  logic                  m1_grant;
  logic                  m2_grant;
  logic                  arbiter_busy;
  logic                  bus_busy;
  logic                  master_sel;
  logic [NUM_SLAVES-1:0] slave_onehot;
  logic                  sel_error;
  logic                  timeout;

  modport master (
    output m1_request, m2_request, m1_slave_sel, m2_slave_sel, trans_done,
    input  m1_grant, m2_grant, arbiter_busy, bus_busy, master_sel,
           slave_onehot, sel_error, timeout
  );

  modport slave (
    input  m1_request, m2_request, m1_slave_sel, m2_slave_sel, trans_done,
    output m1_grant, m2_grant, arbiter_busy, bus_busy, master_sel,
           slave_onehot, sel_error, timeout
  );
endinterface

// File: rtl/bus_arbiter_ctrl.sv
// Two-master / three-slave round-robin bus arbiter with registered grants and selects.
// Define TIMEOUT_EN to build the ACTIVE-state watchdog that revokes a stuck grant.
module bus_arbiter_ctrl #(
  parameter int SLAVE_LEN      = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  bus_arbiter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SELECT, ACTIVE, RELEASE} state_t;

  state_t               state;
  logic [SLAVE_LEN-1:0] sel_slave;
  logic                 last_master;
  logic                 granted;

  logic                 winner;
  logic [SLAVE_LEN-1:0] winner_sel;
  logic                 winner_req;
  logic                 sel_invalid;
  logic                 expired;

  // On a tie the master that did not own the bus last time wins.
  assign winner      = (bus.m1_request && bus.m2_request) ? ~last_master : bus.m2_request;
  assign winner_sel  = winner ? bus.m2_slave_sel : bus.m1_slave_sel;
  assign winner_req  = bus.master_sel ? bus.m2_request : bus.m1_request;
  assign sel_invalid = 32'(sel_slave) >= 32'(NUM_SLAVES);

`ifdef TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] active_count;

  assign expired = !bus.trans_done && (active_count + 16'd1 == TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst || state != ACTIVE) begin
      active_count <= '0;
    end else begin
      active_count <= active_count + 16'd1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      sel_slave        <= '0;
      last_master      <= 1'b1;
      granted          <= 1'b0;
      bus.m1_grant     <= 1'b0;
      bus.m2_grant     <= 1'b0;
      bus.arbiter_busy <= 1'b0;
      bus.bus_busy     <= 1'b0;
      bus.master_sel   <= 1'b0;
      bus.slave_onehot <= '0;
      bus.sel_error    <= 1'b0;
      bus.timeout      <= 1'b0;
    end else begin
      bus.sel_error <= 1'b0;
      bus.timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.m1_request || bus.m2_request) begin
            state            <= SELECT;
            bus.master_sel   <= winner;
            sel_slave        <= winner_sel;
            bus.arbiter_busy <= 1'b1;
            granted          <= 1'b0;
          end
        end
        SELECT: begin
          if (sel_invalid || !winner_req) begin
            state            <= RELEASE;
            bus.arbiter_busy <= 1'b0;
            bus.sel_error    <= sel_invalid;
          end else begin
            state            <= ACTIVE;
            granted          <= 1'b1;
            bus.m1_grant     <= ~bus.master_sel;
            bus.m2_grant     <= bus.master_sel;
            bus.bus_busy     <= 1'b1;
            bus.slave_onehot <= NUM_SLAVES'(1) << sel_slave;
          end
        end
        ACTIVE: begin
          if (bus.trans_done || expired) begin
            state            <= RELEASE;
            bus.m1_grant     <= 1'b0;
            bus.m2_grant     <= 1'b0;
            bus.bus_busy     <= 1'b0;
            bus.arbiter_busy <= 1'b0;
            bus.slave_onehot <= '0;
            bus.timeout      <= expired;
          end
        end
        RELEASE: begin
          // Round-robin history only advances when the bus was actually handed over.
          if (granted) begin
            last_master <= bus.master_sel;
          end
          granted        <= 1'b0;
          bus.master_sel <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Self-checking bench for bus_arbiter_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_bus_arbiter_ctrl;
  localparam int SLAVE_LEN  = 2;
  localparam int NUM_SLAVES = 3;
`ifdef TIMEOUT_EN
  localparam int TO_CYCLES = 8;
`else
  localparam int TO_CYCLES = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   checking = 1'b0;
  bit   rq1, rq2, rdone, rrst;
  int   rs1, rs2;

  always #5 clk = ~clk;

  bus_arbiter_ctrl_if #(.SLAVE_LEN(SLAVE_LEN), .NUM_SLAVES(NUM_SLAVES)) bus ();

  bus_arbiter_ctrl #(
    .SLAVE_LEN(SLAVE_LEN),
    .NUM_SLAVES(NUM_SLAVES),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Transaction view: who holds the bus, whether a decision awaits validation, whether
  // the one-cycle gap after a transaction is in progress, and the round-robin history.
  typedef struct packed {
    int owner;
    int pick;
    int tgt;
    int last;
    int age;
    bit pending;
    bit gap;
    bit granted;
    bit err;
    bit to;
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, bit r, bit q1, bit q2, int s1, int s2, bit done);
    model_t n = s;
    if (!r) begin
      n = '0;
      n.last = 2;
      return n;
    end
    if (s.gap) begin
      if (s.granted) n.last = s.pick;
      n.gap = 1'b0;
      n.err = 1'b0;
      n.to = 1'b0;
      n.pick = 0;
      n.granted = 1'b0;
    end else if (s.pending) begin
      n.pending = 1'b0;
      if (s.tgt >= NUM_SLAVES) begin
        n.gap = 1'b1;
        n.err = 1'b1;
      end else if (!(s.pick == 1 ? q1 : q2)) begin
        n.gap = 1'b1;
      end else begin
        n.owner = s.pick;
        n.granted = 1'b1;
        n.age = 0;
      end
    end else if (s.owner != 0) begin
      n.age = s.age + 1;
      if (done) begin
        n.owner = 0;
        n.gap = 1'b1;
      end
`ifdef TIMEOUT_EN
      else if (n.age == TO_CYCLES) begin
        n.owner = 0;
        n.gap = 1'b1;
        n.to = 1'b1;
      end
`endif
    end else if (q1 || q2) begin
      n.pick = (q1 && q2) ? (s.last == 1 ? 2 : 1) : (q1 ? 1 : 2);
      n.tgt = (n.pick == 1) ? s1 : s2;
      n.pending = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= step(m, rst, bus.m1_request, bus.m2_request, int'(bus.m1_slave_sel),
              int'(bus.m2_slave_sel), bus.trans_done);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit q1, input int s1, input bit q2, input int s2, input bit done);
    rst = r;
    bus.m1_request = q1;
    bus.m1_slave_sel = SLAVE_LEN'(s1);
    bus.m2_request = q2;
    bus.m2_slave_sel = SLAVE_LEN'(s2);
    bus.trans_done = done;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("m1_grant", bus.m1_grant, m.owner == 1);
      checkOutput("m2_grant", bus.m2_grant, m.owner == 2);
      checkOutput("bus_busy", bus.bus_busy, m.owner != 0);
      checkOutput("arbiter_busy", bus.arbiter_busy, m.pending || m.owner != 0);
      checkOutput("master_sel", bus.master_sel,
                  (m.pending || m.owner != 0 || m.gap) ? (m.pick == 2) : 1'b0);
      checkOutput("slave_onehot", bus.slave_onehot, m.owner != 0 ? (32'd1 << m.tgt) : 32'd0);
      checkOutput("sel_error", bus.sel_error, m.err);
      checkOutput("timeout", bus.timeout, m.to);
      checkOutput("single_grant", bus.m1_grant && bus.m2_grant, 1'b0);
    end
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick(2);
    checking = 1'b1;
    checkOutput("rst_grants", {bus.m1_grant, bus.m2_grant}, 0);
    checkOutput("rst_busy", {bus.arbiter_busy, bus.bus_busy}, 0);
    checkOutput("rst_sel", {bus.master_sel, bus.slave_onehot}, 0);
    checkOutput("rst_pulses", {bus.sel_error, bus.timeout}, 0);

    // Single M1 request to slave 1
    applyStimulus(1, 1, 1, 0, 0, 0);
    tick(1);
    checkOutput("t1_select_busy", bus.arbiter_busy, 1);
    checkOutput("t1_select_nogrant", bus.m1_grant, 0);
    tick(1);
    checkOutput("t1_grant", bus.m1_grant, 1);
    checkOutput("t1_onehot", bus.slave_onehot, 3'b010);
    checkOutput("t1_master_sel", bus.master_sel, 0);
    applyStimulus(1, 0, 1, 0, 0, 1);
    tick(1);
    checkOutput("t1_drop", bus.m1_grant, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick(2);

    // Ties from reset alternate M1, M2, M1
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick(1);
    applyStimulus(1, 1, 0, 1, 2, 0);
    tick(2);
    checkOutput("t2_first_m1", bus.m1_grant, 1);
    checkOutput("t2_first_onehot", bus.slave_onehot, 3'b001);
    applyStimulus(1, 1, 0, 1, 2, 1);
    tick(1);
    applyStimulus(1, 1, 0, 1, 2, 0);
    tick(2);
    checkOutput("t2_m2_not_yet", bus.m2_grant, 0);
    tick(1);
    checkOutput("t2_m2_grant", bus.m2_grant, 1);
    checkOutput("t2_m2_onehot", bus.slave_onehot, 3'b100);
    applyStimulus(1, 1, 0, 1, 2, 1);
    tick(1);
    applyStimulus(1, 1, 0, 1, 2, 0);
    tick(3);
    checkOutput("t2_third_m1", bus.m1_grant, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick(1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick(2);

    // Invalid slave select is rejected with a single error pulse
    applyStimulus(1, 0, 0, 1, 3, 0);
    tick(2);
    checkOutput("t3_sel_error", bus.sel_error, 1);
    checkOutput("t3_no_grant", bus.m2_grant, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick(1);
    checkOutput("t3_error_once", bus.sel_error, 0);
    checkOutput("t3_idle", bus.arbiter_busy, 0);

    // Reset during an M2 transfer clears outputs and round-robin history
    applyStimulus(1, 0, 0, 1, 1, 0);
    tick(2);
    checkOutput("t4_m2_grant", bus.m2_grant, 1);
    applyStimulus(0, 1, 0, 1, 1, 0);
    tick(1);
    checkOutput("t4_rst_grants", {bus.m1_grant, bus.m2_grant}, 0);
    checkOutput("t4_rst_outputs", {bus.arbiter_busy, bus.bus_busy, bus.master_sel, bus.slave_onehot}, 0);
    applyStimulus(1, 1, 0, 1, 1, 0);
    tick(2);
    checkOutput("t4_tie_m1", bus.m1_grant, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick(1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick(2);

    // Stray trans_done in IDLE, then a held M1 request waits out an M2 transfer
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick(1);
    checkOutput("t5_idle_done", bus.arbiter_busy, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    tick(2);
    checkOutput("t5_m2_grant", bus.m2_grant, 1);
    applyStimulus(1, 1, 2, 1, 0, 0);
    tick(3);
    checkOutput("t5_m2_holds", bus.m2_grant, 1);
    checkOutput("t5_m1_waits", bus.m1_grant, 0);
    applyStimulus(1, 1, 2, 1, 0, 1);
    tick(1);
    applyStimulus(1, 1, 2, 0, 0, 0);
    tick(2);
    checkOutput("t5_m1_not_yet", bus.m1_grant, 0);
    tick(1);
    checkOutput("t5_m1_grant", bus.m1_grant, 1);
    checkOutput("t5_m1_onehot", bus.slave_onehot, 3'b100);
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick(1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick(2);

`ifdef TIMEOUT_EN
    // Watchdog revokes an M1 grant after eight ACTIVE cycles, then M2 is served
    applyStimulus(1, 1, 0, 0, 0, 0);
    tick(2);
    checkOutput("to_m1_grant", bus.m1_grant, 1);
    applyStimulus(1, 1, 0, 1, 1, 0);
    tick(7);
    checkOutput("to_still_granted", bus.m1_grant, 1);
    tick(1);
    checkOutput("to_revoked", bus.m1_grant, 0);
    checkOutput("to_pulse", bus.timeout, 1);
    tick(1);
    checkOutput("to_pulse_once", bus.timeout, 0);
    tick(2);
    checkOutput("to_m2_served", bus.m2_grant, 1);
    checkOutput("to_m2_onehot", bus.slave_onehot, 3'b010);
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick(1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick(2);
`endif

    // Randomized traffic: masters hold requests for a while, done strobes arrive at random
    rq1 = 1'b0;
    rq2 = 1'b0;
    rs1 = 0;
    rs2 = 0;
    for (int i = 0; i < 3000; i++) begin
      rrst = ($urandom_range(0, 199) != 0);
      if (rq1) begin
        if ($urandom_range(0, 5) == 0) rq1 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        rq1 = 1'b1;
        rs1 = $urandom_range(0, 3);
      end
      if (rq2) begin
        if ($urandom_range(0, 5) == 0) rq2 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        rq2 = 1'b1;
        rs2 = $urandom_range(0, 3);
      end
      rdone = ($urandom_range(0, 3) == 0);
      applyStimulus(rrst, rq1, rs1, rq2, rs2, rdone);
      tick(1);
    end

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
